// File: rtl/bucket_mem_pkg.sv
// ==== bucket_mem_pkg: shared types, sizing helpers and identity-point constants (rev 1.0) ====
`default_nettype none

package bucket_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } clr_state_t;

   localparam int ERR_CA_CLR   = 0;
   localparam int ERR_CLR_BUSY = 1;
   localparam int ERR_RANGE    = 2;

   function automatic int word_w(input int num_coord, input int pnt_w);
      return num_coord * pnt_w;
   endfunction

   function automatic int num_slices(input int word, input int slice_w);
      return (word + slice_w - 1) / slice_w;
   endfunction

   // Montgomery one (2^384 mod p) for each base field
   localparam logic [383:0] R_377 = 384'h8d6661e2fdf49a4cf495bf803c84e87b4e97b76e7c63059f7db3a98a7d3ff251409f837fffffb102cdffffffffff68;
   localparam logic [383:0] R_381 = 384'h15f65ec3fa80e4935c071a97a256ec6d77ce5853705257455f48985753c758baebf4000bc40c0002760900000002fffd;

   // Extended-coordinate identity {Z, T, Y, X} = {1, 0, 1, 0}
   localparam logic [4*377-1:0] ID_377_MONT    = {R_377[376:0], 377'd0, R_377[376:0], 377'd0};
   localparam logic [4*377-1:0] ID_377_BARRETT = {377'd1, 377'd0, 377'd1, 377'd0};
   localparam logic [4*381-1:0] ID_381_MONT    = {R_381[380:0], 381'd0, R_381[380:0], 381'd0};
   localparam logic [4*381-1:0] ID_381_BARRETT = {381'd1, 381'd0, 381'd1, 381'd0};

endpackage

`default_nettype wire

// File: rtl/bucket_mem_slice.sv
// ==== bucket_mem_slice: one simple-dual-port slice, read_first, fixed read latency (rev 1.0) ====
`default_nettype none

module bucket_mem_slice #(
   parameter int P_SLICE_W        = 72,
   parameter int P_DEPTH          = 28672,
   parameter int P_ADDR_W         = 15,
   parameter int P_RD_LAT         = 9,
   parameter     P_MEM_MACRO_TYPE = "ultra"
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [P_ADDR_W-1:0]  waddr,
   input  logic [P_SLICE_W-1:0] wdata,
   input  logic [P_ADDR_W-1:0]  raddr,
   output logic [P_SLICE_W-1:0] rdata
);

   logic [P_SLICE_W-1:0] mem_q;
   logic [P_SLICE_W-1:0] rd_sr [P_RD_LAT-1];

   // Array read and write share one edge, so a colliding read sees the old word
   if (P_MEM_MACRO_TYPE == "ultra") begin : g_uram
      (* ram_style = "ultra" *) logic [P_SLICE_W-1:0] mem [P_DEPTH];
      always_ff @(posedge clk) begin
         if (we) mem[waddr] <= wdata;
         mem_q <= (32'(raddr) < P_DEPTH) ? mem[raddr] : '0;
      end
   end else begin : g_bram
      (* ram_style = "block" *) logic [P_SLICE_W-1:0] mem [P_DEPTH];
      always_ff @(posedge clk) begin
         if (we) mem[waddr] <= wdata;
         mem_q <= (32'(raddr) < P_DEPTH) ? mem[raddr] : '0;
      end
   end

   always_ff @(posedge clk) begin
      rd_sr[0] <= mem_q;
      for (int i = 1; i < P_RD_LAT - 1; i++) rd_sr[i] <= rd_sr[i-1];
   end

   assign rdata = rd_sr[P_RD_LAT-2];

endmodule

`default_nettype wire

// File: rtl/bucket_memory_v2.sv
// ==== bucket_memory_v2: sliced bucket store with clear sequencer, tagged reads and release pipe (rev 1.0) ====
`default_nettype none

module bucket_memory_v2
   import bucket_mem_pkg::*;
#(
   parameter int P_DATA_PNT_W     = 377,
   parameter int P_NUM_COORD      = 4,
   parameter int P_NUM_WIN        = 7,
   parameter int P_BKT_ADDR_W     = 12,
   parameter int P_RD_LAT         = 9,
   parameter int P_REL_LAT        = 2,
   parameter int P_SLICE_W        = 72,
   parameter     P_MEM_MACRO_TYPE = "ultra",
   parameter logic [P_NUM_COORD*P_DATA_PNT_W-1:0] P_INIT_VAL = ID_377_MONT
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 rd_valid_i,
   input  logic [P_BKT_ADDR_W-1:0]              rd_bkt_addr_i,
   input  logic [$clog2(P_NUM_WIN)-1:0]         rd_set_addr_i,
   output logic                                 rd_valid_o,
   output logic [P_BKT_ADDR_W-1:0]              rd_bkt_addr_o,
   output logic [$clog2(P_NUM_WIN)-1:0]         rd_set_addr_o,
   output logic [P_NUM_COORD*P_DATA_PNT_W-1:0]  rd_data_o,
   input  logic                                 ca_valid_i,
   input  logic [P_NUM_COORD*P_DATA_PNT_W-1:0]  ca_sum_i,
   input  logic [P_BKT_ADDR_W-1:0]              ca_bucket_addr_i,
   input  logic [$clog2(P_NUM_WIN)-1:0]         ca_bucket_set_addr_i,
   input  logic                                 clr_start_i,
   input  logic [$clog2(P_NUM_WIN)-1:0]         clr_set_addr_i,
   output logic                                 clr_busy_o,
   output logic                                 clr_done_o,
   output logic                                 sch_valid_o,
   output logic [P_BKT_ADDR_W-1:0]              sch_bucket_addr_o,
   output logic [$clog2(P_NUM_WIN)-1:0]         sch_bucket_set_addr_o,
   output logic [2:0]                           err_o
);

   localparam int SET_W  = $clog2(P_NUM_WIN);
   localparam int BKT_W  = P_BKT_ADDR_W;
   localparam int ADDR_W = SET_W + BKT_W;
   localparam int WORD   = word_w(P_NUM_COORD, P_DATA_PNT_W);
   localparam int NS     = num_slices(WORD, P_SLICE_W);
   localparam int PAD_W  = NS * P_SLICE_W;
   localparam int DEPTH  = P_NUM_WIN * (2 ** BKT_W);
   localparam logic [SET_W-1:0] LAST_SET = SET_W'(P_NUM_WIN - 1);

   clr_state_t        state, state_nxt;
   logic [SET_W-1:0]  clr_set;
   logic [BKT_W-1:0]  cnt;
   logic              clr_we;
   logic              ca_set_ok, clr_set_ok, ca_we, we;
   logic [ADDR_W-1:0] waddr, raddr;
   logic [PAD_W-1:0]  wdata_pad, rdata_pad;
   logic [2:0]        err_set;

   logic [P_RD_LAT-1:0]             rd_v_sr;
   logic [P_RD_LAT-1:0][BKT_W-1:0]  rd_bkt_sr;
   logic [P_RD_LAT-1:0][SET_W-1:0]  rd_set_sr;
   logic [P_REL_LAT-1:0]            rel_v_sr;
   logic [P_REL_LAT-1:0][BKT_W-1:0] rel_bkt_sr;
   logic [P_REL_LAT-1:0][SET_W-1:0] rel_set_sr;

   assign ca_set_ok  = (ca_bucket_set_addr_i <= LAST_SET);
   assign clr_set_ok = (clr_set_addr_i <= LAST_SET);
   assign ca_we      = ca_valid_i && ca_set_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (clr_start_i && clr_set_ok) state_nxt = SWEEP;
         SWEEP:   if (!ca_valid_i && (&cnt))     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Any curve-adder strobe owns the write port, so the sweep stalls on it
   always_comb begin
      clr_busy_o = (state == SWEEP);
      clr_done_o = (state == DONE);
      clr_we     = (state == SWEEP) && !ca_valid_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_set <= '0;
         cnt     <= '0;
      end else if (state == IDLE && clr_start_i && clr_set_ok) begin
         clr_set <= clr_set_addr_i;
         cnt     <= '0;
      end else if (clr_we) begin
         cnt <= cnt + BKT_W'(1);
      end
   end

   assign err_set[ERR_CA_CLR]   = ca_valid_i && (state == SWEEP) && (ca_bucket_set_addr_i == clr_set);
   assign err_set[ERR_CLR_BUSY] = clr_start_i && (state != IDLE);
   assign err_set[ERR_RANGE]    = (ca_valid_i && !ca_set_ok) ||
                                  (clr_start_i && (state == IDLE) && !clr_set_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_o <= '0;
      else        err_o <= err_o | err_set;
   end

   assign we        = ca_we || clr_we;
   assign waddr     = ca_valid_i ? {ca_bucket_set_addr_i, ca_bucket_addr_i} : {clr_set, cnt};
   assign wdata_pad = PAD_W'(ca_valid_i ? ca_sum_i : P_INIT_VAL);
   assign raddr     = {rd_set_addr_i, rd_bkt_addr_i};

   for (genvar i = 0; i < NS; i++) begin : g_slice
      bucket_mem_slice #(
         .P_SLICE_W        (P_SLICE_W),
         .P_DEPTH          (DEPTH),
         .P_ADDR_W         (ADDR_W),
         .P_RD_LAT         (P_RD_LAT),
         .P_MEM_MACRO_TYPE (P_MEM_MACRO_TYPE)
      ) u_slice (
         .clk   (clk),
         .we    (we),
         .waddr (waddr),
         .wdata (wdata_pad[i*P_SLICE_W +: P_SLICE_W]),
         .raddr (raddr),
         .rdata (rdata_pad[i*P_SLICE_W +: P_SLICE_W])
      );
   end

   if (PAD_W > WORD) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^rdata_pad[PAD_W-1:WORD];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_v_sr    <= '0;
         rd_bkt_sr  <= '0;
         rd_set_sr  <= '0;
         rel_v_sr   <= '0;
         rel_bkt_sr <= '0;
         rel_set_sr <= '0;
      end else begin
         rd_v_sr[0]    <= rd_valid_i;
         rd_bkt_sr[0]  <= rd_bkt_addr_i;
         rd_set_sr[0]  <= rd_set_addr_i;
         for (int i = 1; i < P_RD_LAT; i++) begin
            rd_v_sr[i]   <= rd_v_sr[i-1];
            rd_bkt_sr[i] <= rd_bkt_sr[i-1];
            rd_set_sr[i] <= rd_set_sr[i-1];
         end
         rel_v_sr[0]   <= ca_we;
         rel_bkt_sr[0] <= ca_bucket_addr_i;
         rel_set_sr[0] <= ca_bucket_set_addr_i;
         for (int i = 1; i < P_REL_LAT; i++) begin
            rel_v_sr[i]   <= rel_v_sr[i-1];
            rel_bkt_sr[i] <= rel_bkt_sr[i-1];
            rel_set_sr[i] <= rel_set_sr[i-1];
         end
      end
   end

   assign rd_valid_o            = rd_v_sr[P_RD_LAT-1];
   assign rd_bkt_addr_o         = rd_bkt_sr[P_RD_LAT-1];
   assign rd_set_addr_o         = rd_set_sr[P_RD_LAT-1];
   // Memory output is not reset; gate it so idle and reset data read as zero
   assign rd_data_o             = rd_valid_o ? rdata_pad[WORD-1:0] : '0;
   assign sch_valid_o           = rel_v_sr[P_REL_LAT-1];
   assign sch_bucket_addr_o     = rel_bkt_sr[P_REL_LAT-1];
   assign sch_bucket_set_addr_o = rel_set_sr[P_REL_LAT-1];

endmodule

`default_nettype wire

// File: tb/tb_bucket_memory_v2.sv
// ==== tb_bucket_memory_v2: directed and random stimulus against a bucket-array reference model (rev 1.0) ====
`default_nettype none

module tb_bucket_memory_v2;
   import bucket_mem_pkg::*;

   localparam int W    = 377;
   localparam int NC   = 4;
   localparam int NW   = 7;
   localparam int BW   = 4;
   localparam int NB   = 16;
   localparam int RL   = 9;
   localparam int RLL  = 2;
   localparam int SW   = 3;
   localparam int WORD = NC * W;
   localparam logic [WORD-1:0] INIT = ID_377_MONT;
   localparam logic [WORD-1:0] PAT  = {12'hABC, {(WORD-16){1'b0}}, 4'h1};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rd_valid = 1'b0;
   logic [BW-1:0] rd_bkt = '0;
   logic [SW-1:0] rd_set = '0;
   logic ca_valid = 1'b0;
   logic [WORD-1:0] ca_sum = '0;
   logic [BW-1:0] ca_bkt = '0;
   logic [SW-1:0] ca_set = '0;
   logic clr_start = 1'b0;
   logic [SW-1:0] clr_set = '0;

   logic rd_valid_o, clr_busy_o, clr_done_o, sch_valid_o;
   logic [BW-1:0] rd_bkt_addr_o, sch_bucket_addr_o;
   logic [SW-1:0] rd_set_addr_o, sch_bucket_set_addr_o;
   logic [WORD-1:0] rd_data_o;
   logic [2:0] err_o;

   bucket_memory_v2 #(
      .P_DATA_PNT_W (W), .P_NUM_COORD (NC), .P_NUM_WIN (NW), .P_BKT_ADDR_W (BW),
      .P_RD_LAT (RL), .P_REL_LAT (RLL), .P_SLICE_W (72)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .rd_valid_i (rd_valid), .rd_bkt_addr_i (rd_bkt), .rd_set_addr_i (rd_set),
      .rd_valid_o (rd_valid_o), .rd_bkt_addr_o (rd_bkt_addr_o), .rd_set_addr_o (rd_set_addr_o),
      .rd_data_o (rd_data_o),
      .ca_valid_i (ca_valid), .ca_sum_i (ca_sum), .ca_bucket_addr_i (ca_bkt),
      .ca_bucket_set_addr_i (ca_set),
      .clr_start_i (clr_start), .clr_set_addr_i (clr_set),
      .clr_busy_o (clr_busy_o), .clr_done_o (clr_done_o),
      .sch_valid_o (sch_valid_o), .sch_bucket_addr_o (sch_bucket_addr_o),
      .sch_bucket_set_addr_o (sch_bucket_set_addr_o),
      .err_o (err_o)
   );

   always #5 clk = ~clk;

   typedef struct { logic [BW-1:0] b; logic [SW-1:0] s; bit known; logic [WORD-1:0] d; } rexp_t;
   typedef struct { logic [BW-1:0] b; logic [SW-1:0] s; } sexp_t;

   rexp_t rq [int];
   sexp_t sq [int];
   logic [WORD-1:0] mdata [NW*NB];
   bit mknown [NW*NB];
   int mst;      // 0 idle, 1 sweeping, 2 done
   int mset, mcnt;
   logic [2:0] merr;
   int cyc, errors, checks;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_d(input string tag, input logic [WORD-1:0] obs, input logic [WORD-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: low bits got %h expected %h (cycle %0d)", tag, obs[95:0], exp[95:0], cyc);
      end
   endtask

   function automatic logic [WORD-1:0] rnd_word();
      logic [WORD-1:0] w = '0;
      for (int i = 0; i < (WORD + 31) / 32; i++) w = {w[WORD-33:0], 32'($urandom())};
      return w;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, ".rd_valid"}, 32'(rd_valid_o), 0);
      chk({tag, ".rd_bkt"}, 32'(rd_bkt_addr_o), 0);
      chk({tag, ".rd_set"}, 32'(rd_set_addr_o), 0);
      chk_d({tag, ".rd_data"}, rd_data_o, '0);
      chk({tag, ".busy"}, 32'(clr_busy_o), 0);
      chk({tag, ".done"}, 32'(clr_done_o), 0);
      chk({tag, ".sch_valid"}, 32'(sch_valid_o), 0);
      chk({tag, ".sch_addr"}, 32'({sch_bucket_set_addr_o, sch_bucket_addr_o}), 0);
      chk({tag, ".err"}, 32'(err_o), 0);
   endtask

   // One clock edge: update the model from the inputs sampled there, then compare
   task automatic tick();
      int idx;
      rexp_t e;
      sexp_t s;
      bit ca_ok;
      @(posedge clk);
      if (rd_valid) begin
         e.b = rd_bkt; e.s = rd_set; e.known = 1'b0; e.d = '0;
         if (int'(rd_set) < NW) begin
            idx = int'(rd_set) * NB + int'(rd_bkt);
            e.known = mknown[idx];
            e.d = mdata[idx];
         end
         rq[cyc + RL - 1] = e;
      end
      ca_ok = ca_valid && (int'(ca_set) < NW);
      if (ca_valid && !ca_ok) merr[2] = 1'b1;
      if (ca_valid && mst == 1 && int'(ca_set) == mset) merr[0] = 1'b1;
      if (clr_start && mst != 0) merr[1] = 1'b1;
      if (clr_start && mst == 0 && int'(clr_set) >= NW) merr[2] = 1'b1;
      if (ca_ok) begin
         idx = int'(ca_set) * NB + int'(ca_bkt);
         mdata[idx] = ca_sum;
         mknown[idx] = 1'b1;
         s.b = ca_bkt; s.s = ca_set;
         sq[cyc + RLL - 1] = s;
      end
      case (mst)
         0: if (clr_start && int'(clr_set) < NW) begin mst = 1; mset = int'(clr_set); mcnt = 0; end
         1: if (!ca_valid) begin
               mdata[mset * NB + mcnt] = INIT;
               mknown[mset * NB + mcnt] = 1'b1;
               if (mcnt == NB - 1) mst = 2; else mcnt++;
            end
         default: mst = 0;
      endcase
      #1;
      if (rq.exists(cyc)) begin
         chk("rd_valid", 32'(rd_valid_o), 1);
         chk("rd_bkt", 32'(rd_bkt_addr_o), 32'(rq[cyc].b));
         chk("rd_set", 32'(rd_set_addr_o), 32'(rq[cyc].s));
         if (rq[cyc].known) chk_d("rd_data", rd_data_o, rq[cyc].d);
         rq.delete(cyc);
      end else chk("rd_valid", 32'(rd_valid_o), 0);
      if (sq.exists(cyc)) begin
         chk("sch_valid", 32'(sch_valid_o), 1);
         chk("sch_bkt", 32'(sch_bucket_addr_o), 32'(sq[cyc].b));
         chk("sch_set", 32'(sch_bucket_set_addr_o), 32'(sq[cyc].s));
         sq.delete(cyc);
      end else chk("sch_valid", 32'(sch_valid_o), 0);
      chk("clr_busy", 32'(clr_busy_o), 32'(mst == 1));
      chk("clr_done", 32'(clr_done_o), 32'(mst == 2));
      chk("err", 32'(err_o), 32'(merr));
      cyc++;
   endtask

   task automatic do_read(input int s, input int b);
      rd_valid = 1'b1; rd_set = SW'(s); rd_bkt = BW'(b);
      tick();
      rd_valid = 1'b0;
   endtask

   task automatic do_write(input int s, input int b, input logic [WORD-1:0] d);
      ca_valid = 1'b1; ca_set = SW'(s); ca_bkt = BW'(b); ca_sum = d;
      tick();
      ca_valid = 1'b0;
   endtask

   task automatic do_clear(input int s);
      clr_start = 1'b1; clr_set = SW'(s);
      tick();
      clr_start = 1'b0;
   endtask

   initial begin
      logic [WORD-1:0] a_val, b_val;
      errors = 0; checks = 0; cyc = 0; mst = 0; mset = 0; mcnt = 0; merr = '0;
      for (int i = 0; i < NW * NB; i++) begin mknown[i] = 1'b0; mdata[i] = '0; end

      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) tick();

      // Clear window 3, then read every bucket of it back
      do_clear(3);
      repeat (18) tick();
      for (int k = 0; k < NB; k++) do_read(3, k);
      repeat (RL) tick();

      // Write then read back on the very next cycle
      do_write(2, 5, PAT);
      do_read(2, 5);
      repeat (RL) tick();

      // Clear window 1 while three writes to window 4 stall the sweep
      do_clear(1);
      repeat (4) tick();
      for (int i = 0; i < 3; i++) begin do_write(4, i, rnd_word()); tick(); end
      repeat (16) tick();
      for (int i = 0; i < 3; i++) do_read(4, i);
      for (int i = 0; i < NB; i += 5) do_read(1, i);
      repeat (RL) tick();

      // Same-cycle read and write of one address returns the old word
      a_val = rnd_word();
      b_val = rnd_word();
      do_write(0, 7, a_val);
      rd_valid = 1'b1; rd_set = 3'd0; rd_bkt = 4'd7;
      do_write(0, 7, b_val);
      do_read(0, 7);
      repeat (RL) tick();

      // Conflict flags: write into the clearing window, restart while busy
      do_clear(1);
      repeat (3) tick();
      do_write(1, 2, rnd_word());
      repeat (3) tick();
      do_clear(5);
      repeat (14) tick();
      do_clear(6);          // lands in DONE or just after; the model decides
      repeat (20) tick();

      // Out-of-range write and clear
      do_write(7, 1, rnd_word());
      do_clear(7);
      do_read(7, 1);
      repeat (RL + 2) tick();

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         rd_valid  = 1'($urandom_range(0, 1));
         rd_set    = SW'($urandom_range(0, NW - 1));
         rd_bkt    = BW'($urandom_range(0, NB - 1));
         ca_valid  = ($urandom_range(0, 3) == 0);
         ca_set    = SW'(($urandom_range(0, 15) == 0) ? 7 : $urandom_range(0, NW - 1));
         ca_bkt    = BW'($urandom_range(0, NB - 1));
         ca_sum    = rnd_word();
         clr_start = ($urandom_range(0, 40) == 0);
         clr_set   = SW'($urandom_range(0, NW - 1));
         tick();
      end
      rd_valid = 1'b0; ca_valid = 1'b0; clr_start = 1'b0;
      repeat (40) tick();

      // Reset in the middle of a sweep with a release still in flight
      do_clear(5);
      repeat (5) tick();
      do_write(0, 3, rnd_word());
      #3;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("in_rst");
      rst_n = 1'b1;
      mst = 0; merr = '0;
      rq.delete();
      sq.delete();
      repeat (20) tick();
      do_read(0, 3);
      do_read(5, 0);
      repeat (RL + 1) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
